idu_stage: RTL and testbench
============================

IDU_STAGE -- requirements
Module: idu_stage

Interface
REQ-001 Parameters SHALL be:
- XLEN, 32, datapath width; legal values 32 and 64.
- NREG, 32, architectural register count; legal values 16 (RV-E) and 32.
- INS_W, 32, instruction width.

REQ-002 Ports SHALL be as follows. Widths: RA = log2(NREG). The clock is one clock; the reset is asynchronous, active-low.
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept
- i_ins  in  INS_W  instruction word
- i_pc  in  XLEN  instruction PC
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  downstream accepts bundle
- o_pc  out  XLEN  PC of bundle
- o_rdid, o_rs1id, o_rs2id  out  RA  register indices
- o_rdwen  out  1  rd write enable
- o_imm  out  XLEN  sign-extended immediate
- o_sysins  out  1  SYSTEM opcode
- o_csrid  out  12  CSR address (ins[31:20] when o_sysins, else 0)
- o_ecall  out  1  ecall
- o_mret  out  1  mret
- o_ebreak  out  1  ebreak
- o_illegal  out  1  illegal-instruction flag
- o_w32  out  1  RV64 word-op (OP-IMM-32/OP-32); 0 when XLEN=32

Function
REQ-003 Transfer SHALL occur on a rising edge: input when i_valid&o_ready; output when o_valid&i_ready.

REQ-004 Buffering SHALL be a 2-entry skid buffer, FSM states EMPTY, ONE, TWO.
- o_ready=1 in EMPTY and ONE, 0 in TWO.
- o_valid=1 in ONE and TWO.

REQ-005 Transitions SHALL be:
- EMPTY->ONE on input.
- ONE->TWO on input without output.
- ONE->EMPTY on output without input.
- ONE stays ONE on simultaneous input and output.
- TWO->ONE on output.

REQ-006 Decode SHALL be performed combinationally on i_ins and registered with the entry. Latency SHALL be 1 cycle: a bundle accepted in cycle N appears on outputs in cycle N+1.

REQ-007 Order SHALL be FIFO. Outputs SHALL present the oldest entry, and the held bundle SHALL remain stable while o_valid&!i_ready.

REQ-008 The immediate SHALL be decoded by format and sign-extended from ins[31] to XLEN:
- I: LOAD, OP-IMM, JALR, OP-IMM-32
- S: STORE
- B: BRANCH
- U: LUI, AUIPC; ins[31:12]<<12, sign-extended
- J: JAL
- SYSTEM: imm = zero-extended ins[19:15] (zimm)
- all others: 0

REQ-009 o_rdwen SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32, and SYSTEM with funct3!=0. o_rdwen SHALL be forced to 0 when rd==0.

REQ-010 Register indices SHALL be ins[11:7], ins[19:15] and ins[24:20], truncated to RA bits. When NREG=16, any used index with bit 4 set SHALL raise o_illegal.

REQ-011 o_illegal SHALL be 1 for any of:
- ins[1:0]!=2'b11;
- opcode outside the supported set;
- OP-IMM-32/OP-32 when XLEN=32;
- SYSTEM with funct3==0 other than ecall/ebreak/mret.
When o_illegal=1, o_rdwen SHALL be 0.

REQ-012 o_ecall SHALL be 1 iff the instruction equals 0x00000073; o_ebreak iff 0x00100073; o_mret iff 0x30200073.

REQ-013 All decoded outputs SHALL be 0 when o_valid=0.

REQ-014 Input SHALL NOT be accepted in TWO; upstream data with o_ready=0 SHALL be ignored.

Reset
REQ-015 On i_rst_n=0 (asynchronous), the FSM SHALL go to EMPTY, o_valid=0 and o_ready=0 while reset is asserted. All stored bundles SHALL be cleared to 0.

REQ-016 After deassertion, o_ready SHALL be 1 from the first clock edge. A reset mid-operation SHALL discard both entries with no output transfer.

Verification
REQ-017 i_ins=0x00500093 (addi x1,x0,5), i_pc=0x80000000, i_ready=1 -> next cycle:
- o_valid=1, o_pc=0x80000000
- o_rdid=1, o_rs1id=0, o_rdwen=1, o_imm=5, o_illegal=0

REQ-018 i_ins=0x12345137 (lui x2), then 0xFFF00093 (addi x1,x0,-1) with XLEN=64 -> o_imm=0x0000000012345000, then 0xFFFFFFFFFFFFFFFF.

REQ-019 Special instructions:
- 0x00000073 -> o_sysins=1, o_ecall=1, o_rdwen=0.
- 0x30200073 -> o_mret=1.
- 0x00000000 -> o_illegal=1, o_rdwen=0.

REQ-020 Hold i_ready=0 and push 3 instructions A, B, C -> o_ready=0 after 2 accepts, C held upstream. Then raise i_ready -> bundles A, B, C emerge in order, one per cycle, with no loss or duplicate.

REQ-021 State ONE with i_valid=1 and i_ready=1 every cycle for 10 cycles -> stays in ONE, 10 in / 10 out, throughput 1 per cycle.

REQ-022 Reset asserted asynchronously in state TWO -> o_valid drops to 0 immediately without a clock edge. After release: o_ready=1, no stale bundle emitted.

Source files
------------

// File: rtl/idu_stage_if.sv
// Decode-stage bus: upstream instruction handshake in, decoded bundle handshake out.
interface idu_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int INS_W = 32
);
    localparam int RA = $clog2(NREG);

    logic             i_valid;
    logic             o_ready;
    logic [INS_W-1:0] i_ins;
    logic [XLEN-1:0]  i_pc;

    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_pc;
    logic [RA-1:0]    o_rdid;
    logic [RA-1:0]    o_rs1id;
    logic [RA-1:0]    o_rs2id;
    logic             o_rdwen;
    logic [XLEN-1:0]  o_imm;
    logic             o_sysins;
    logic [11:0]      o_csrid;
    logic             o_ecall;
    logic             o_mret;
    logic             o_ebreak;
    logic             o_illegal;
    logic             o_w32;

    modport slave (
        input  i_valid, i_ins, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_rdid, o_rs1id, o_rs2id, o_rdwen, o_imm,
               o_sysins, o_csrid, o_ecall, o_mret, o_ebreak, o_illegal, o_w32
    );

    modport master (
        output i_valid, i_ins, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_rdid, o_rs1id, o_rs2id, o_rdwen, o_imm,
               o_sysins, o_csrid, o_ecall, o_mret, o_ebreak, o_illegal, o_w32
    );
endinterface

// File: rtl/idu_stage.sv
// RV instruction decode stage: combinational decode registered into a 2-entry skid buffer, 1-cycle latency.
// Backpressure: o_ready drops only when both entries are held; outputs show the oldest entry, stable while stalled.
module idu_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int INS_W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    idu_stage_if.slave   bus
);
    localparam int RA = $clog2(NREG);

    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_OPIMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_OPIMM32 = 7'h1b;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_OP      = 7'h33;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_OP32    = 7'h3b;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_JAL     = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA-1:0]   rdid;
        logic [RA-1:0]   rs1id;
        logic [RA-1:0]   rs2id;
        logic            rdwen;
        logic [XLEN-1:0] imm;
        logic            sysins;
        logic [11:0]     csrid;
        logic            ecall;
        logic            mret;
        logic            ebreak;
        logic            illegal;
        logic            w32;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            wr_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            opc_ok;
    logic            is_w;
    logic            is_ecall;
    logic            is_ebreak;
    logic            is_mret;
    logic            ill;
    logic [XLEN-1:0] imm_x;
    bundle_t         dec;

    always_comb begin
        ins     = bus.i_ins[31:0];
        opc     = ins[6:0];
        f3      = ins[14:12];
        wr_rd   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        opc_ok  = 1'b1;
        imm_x   = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                wr_rd = 1'b1;
                imm_x = XLEN'({{32{ins[31]}}, ins[31:12], 12'h000});
            end
            OPC_JAL: begin
                wr_rd = 1'b1;
                imm_x = XLEN'({{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0});
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: begin
                wr_rd   = 1'b1;
                use_rs1 = 1'b1;
                imm_x   = XLEN'({{52{ins[31]}}, ins[31:20]});
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_x   = XLEN'({{52{ins[31]}}, ins[31:25], ins[11:7]});
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_x   = XLEN'({{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0});
            end
            OPC_OP, OPC_OP32: begin
                wr_rd   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_SYSTEM: begin
                // CSR ops write rd; only the register forms (funct3 1..3) read rs1
                wr_rd   = (f3 != 3'd0);
                use_rs1 = (f3 != 3'd0) && !f3[2];
                imm_x   = XLEN'({59'd0, ins[19:15]});
            end
            default: opc_ok = 1'b0;
        endcase

        is_w      = (opc == OPC_OPIMM32) || (opc == OPC_OP32);
        is_ecall  = (ins == 32'h0000_0073);
        is_ebreak = (ins == 32'h0010_0073);
        is_mret   = (ins == 32'h3020_0073);
        ill = !opc_ok
            || (is_w && (XLEN == 32))
            || ((opc == OPC_SYSTEM) && (f3 == 3'd0) && !(is_ecall || is_ebreak || is_mret))
            || ((NREG == 16) && ((wr_rd && ins[11]) || (use_rs1 && ins[19]) || (use_rs2 && ins[24])));

        dec         = '0;
        dec.pc      = bus.i_pc;
        dec.rdid    = ins[7 +: RA];
        dec.rs1id   = ins[15 +: RA];
        dec.rs2id   = ins[20 +: RA];
        dec.rdwen   = wr_rd && (ins[11:7] != 5'd0) && !ill;
        dec.imm     = imm_x;
        dec.sysins  = (opc == OPC_SYSTEM);
        dec.csrid   = (opc == OPC_SYSTEM) ? ins[31:20] : 12'h000;
        dec.ecall   = is_ecall;
        dec.mret    = is_mret;
        dec.ebreak  = is_ebreak;
        dec.illegal = ill;
        dec.w32     = is_w && (XLEN == 64);
    end

    state_t  state_q, state_d;
    bundle_t ent0_q, ent1_q;
    bundle_t head;
    logic    rdy_en_q;
    logic    out_vld, out_rdy;
    logic    push, pop;

    // rdy_en_q keeps o_ready low through reset and releases it on the first edge after
    assign out_vld = (state_q != EMPTY);
    assign out_rdy = rdy_en_q && (state_q != TWO);
    assign push    = bus.i_valid && out_rdy;
    assign pop     = out_vld && bus.i_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (!push && pop) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= EMPTY;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            case (state_q)
                EMPTY: if (push) ent0_q <= dec;
                ONE: begin
                    if (push && pop)  ent0_q <= dec;
                    else if (push)    ent1_q <= dec;
                    else if (pop)     ent0_q <= '0;
                end
                TWO: if (pop) begin
                    ent0_q <= ent1_q;
                    ent1_q <= '0;
                end
                default: begin
                    ent0_q <= '0;
                    ent1_q <= '0;
                end
            endcase
        end
    end

    assign head = out_vld ? ent0_q : '0;

    assign bus.o_ready   = out_rdy;
    assign bus.o_valid   = out_vld;
    assign bus.o_pc      = head.pc;
    assign bus.o_rdid    = head.rdid;
    assign bus.o_rs1id   = head.rs1id;
    assign bus.o_rs2id   = head.rs2id;
    assign bus.o_rdwen   = head.rdwen;
    assign bus.o_imm     = head.imm;
    assign bus.o_sysins  = head.sysins;
    assign bus.o_csrid   = head.csrid;
    assign bus.o_ecall   = head.ecall;
    assign bus.o_mret    = head.mret;
    assign bus.o_ebreak  = head.ebreak;
    assign bus.o_illegal = head.illegal;
    assign bus.o_w32     = head.w32;
endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: an RV64/32-reg and an RV32/16-reg instance driven in lockstep against a queue-based reference.
module tb_idu_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idu_stage_if #(.XLEN(64), .NREG(32), .INS_W(32)) b64();
    idu_stage_if #(.XLEN(32), .NREG(16), .INS_W(32)) b32();

    idu_stage #(.XLEN(64), .NREG(32), .INS_W(32)) dut64 (.i_clk(clk), .i_rst_n(rst_n), .bus(b64.slave));
    idu_stage #(.XLEN(32), .NREG(16), .INS_W(32)) dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(b32.slave));

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdwen;
        logic [63:0] imm;
        logic [11:0] csr;
        logic [5:0]  flg;   // {sysins, ecall, mret, ebreak, illegal, w32}
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   dut_in = 0;
    int   dut_out = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xlen, input int nreg);
        exp_t        e;
        logic [6:0]  op;
        int          f3;
        longint      imm;
        logic [63:0] mask;
        bit          wr, r1, r2, known, ill, is_w, ec, eb, mr;
        op = ins[6:0];
        f3 = int'(ins[14:12]);
        imm = 0; wr = 0; r1 = 0; r2 = 0;
        known = op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h73};
        case (op)
            7'h37, 7'h17: begin wr = 1; imm = longint'(int'(ins & 32'hFFFF_F000)); end
            7'h6f: begin
                wr = 1;
                imm = longint'(int'(ins) >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'h67, 7'h03, 7'h13, 7'h1b: begin wr = 1; r1 = 1; imm = longint'(int'(ins) >>> 20); end
            7'h23: begin r1 = 1; r2 = 1; imm = longint'(int'(ins) >>> 25) * 32 + longint'(ins[11:7]); end
            7'h63: begin
                r1 = 1; r2 = 1;
                imm = longint'(int'(ins) >>> 31) * 4096 + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h33, 7'h3b: begin wr = 1; r1 = 1; r2 = 1; end
            7'h73: begin wr = (f3 != 0); r1 = (f3 >= 1 && f3 <= 3); imm = longint'(ins[19:15]); end
            default: ;
        endcase
        is_w = (op == 7'h1b) || (op == 7'h3b);
        ec = (ins == 32'h0000_0073);
        eb = (ins == 32'h0010_0073);
        mr = (ins == 32'h3020_0073);
        ill = !known || (is_w && xlen == 32) || (op == 7'h73 && f3 == 0 && !(ec || eb || mr));
        if (nreg == 16 && ((wr && ins[11]) || (r1 && ins[19]) || (r2 && ins[24]))) ill = 1;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.pc    = pc & mask;
        e.imm   = 64'(imm) & mask;
        e.rd    = (nreg == 16) ? {1'b0, ins[10:7]}  : ins[11:7];
        e.rs1   = (nreg == 16) ? {1'b0, ins[18:15]} : ins[19:15];
        e.rs2   = (nreg == 16) ? {1'b0, ins[23:20]} : ins[24:20];
        e.rdwen = wr && (ins[11:7] != 0) && !ill;
        e.csr   = (op == 7'h73) ? ins[31:20] : 12'h000;
        e.flg   = {op == 7'h73, ec, mr, eb, ill, is_w && xlen == 64};
        return e;
    endfunction

    task automatic cmp_bundle(input string p, input exp_t got, input exp_t exp,
                              input logic gv, input logic gr, input logic ev, input logic er);
        chk({p, "_valid"}, gv, ev);
        chk({p, "_ready"}, gr, er);
        chk({p, "_pc"}, got.pc, exp.pc);
        chk({p, "_regs"}, {got.rd, got.rs1, got.rs2}, {exp.rd, exp.rs1, exp.rs2});
        chk({p, "_rdwen"}, got.rdwen, exp.rdwen);
        chk({p, "_imm"}, got.imm, exp.imm);
        chk({p, "_csr"}, got.csr, exp.csr);
        chk({p, "_flags"}, got.flg, exp.flg);
    endtask

    task automatic check_all();
        exp_t g, e;
        g.pc = b64.o_pc; g.rd = b64.o_rdid; g.rs1 = b64.o_rs1id; g.rs2 = b64.o_rs2id;
        g.rdwen = b64.o_rdwen; g.imm = b64.o_imm; g.csr = b64.o_csrid;
        g.flg = {b64.o_sysins, b64.o_ecall, b64.o_mret, b64.o_ebreak, b64.o_illegal, b64.o_w32};
        e = (q64.size() != 0) ? q64[0] : '0;
        cmp_bundle("d64", g, e, b64.o_valid, b64.o_ready, q64.size() != 0, q64.size() < 2);
        g.pc = 64'(b32.o_pc); g.rd = 5'(b32.o_rdid); g.rs1 = 5'(b32.o_rs1id); g.rs2 = 5'(b32.o_rs2id);
        g.rdwen = b32.o_rdwen; g.imm = 64'(b32.o_imm); g.csr = b32.o_csrid;
        g.flg = {b32.o_sysins, b32.o_ecall, b32.o_mret, b32.o_ebreak, b32.o_illegal, b32.o_w32};
        e = (q32.size() != 0) ? q32[0] : '0;
        cmp_bundle("d32", g, e, b32.o_valid, b32.o_ready, q32.size() != 0, q32.size() < 2);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic r);
        b64.i_valid = v; b64.i_ins = ins; b64.i_pc = pc;        b64.i_ready = r;
        b32.i_valid = v; b32.i_ins = ins; b32.i_pc = pc[31:0];  b32.i_ready = r;
    endtask

    // Called at a falling edge: apply inputs, advance the reference across the rising edge, then compare
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic r);
        int n;
        drive(v, ins, pc, r);
        n = q64.size();
        if (b64.o_ready && v) dut_in++;
        if (b64.o_valid && r) dut_out++;
        if (n > 0 && r) begin
            void'(q64.pop_front());
            void'(q32.pop_front());
        end
        if (v && n < 2) begin
            q64.push_back(ref_dec(ins, pc, 64, 32));
            q32.push_back(ref_dec(ins, pc, 32, 16));
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        q64.delete();
        q32.delete();
        repeat (2) @(negedge clk);
        chk("rst_valid64", b64.o_valid, 1'b0);
        chk("rst_ready64", b64.o_ready, 1'b0);
        chk("rst_valid32", b32.o_valid, 1'b0);
        chk("rst_ready32", b32.o_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready64", b64.o_ready, 1'b1);
        chk("post_rst_ready32", b32.o_ready, 1'b1);
        chk("post_rst_valid64", b64.o_valid, 1'b0);
    endtask

    function automatic logic [31:0] gen_ins();
        logic [31:0] x;
        int k;
        x = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: x[6:0] = 7'h37;   1: x[6:0] = 7'h17;   2: x[6:0] = 7'h6f;   3: x[6:0] = 7'h67;
            4: x[6:0] = 7'h63;   5: x[6:0] = 7'h03;   6: x[6:0] = 7'h23;   7: x[6:0] = 7'h13;
            8: x[6:0] = 7'h33;   9: x[6:0] = 7'h1b;  10: x[6:0] = 7'h3b;  11: x[6:0] = 7'h73;
            12: x = 32'h0000_0073;
            13: x = 32'h0010_0073;
            14: x = 32'h3020_0073;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        @(negedge clk);
        do_reset();

        // addi x1,x0,5
        step(1'b1, 32'h0050_0093, 64'h8000_0000, 1'b1);
        chk("addi_valid", b64.o_valid, 1'b1);
        chk("addi_pc", b64.o_pc, 64'h8000_0000);
        chk("addi_rd_rs1", {b64.o_rdid, b64.o_rs1id}, {5'd1, 5'd0});
        chk("addi_rdwen", b64.o_rdwen, 1'b1);
        chk("addi_imm", b64.o_imm, 64'd5);
        chk("addi_ill", b64.o_illegal, 1'b0);

        step(1'b1, 32'h1234_5137, 64'h8000_0004, 1'b1);
        chk("lui_imm64", b64.o_imm, 64'h0000_0000_1234_5000);
        step(1'b1, 32'hFFF0_0093, 64'h8000_0008, 1'b1);
        chk("addim1_imm64", b64.o_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addim1_imm32", b32.o_imm, 32'hFFFF_FFFF);

        step(1'b1, 32'h0000_0073, 64'h8000_000c, 1'b1);
        chk("ecall_flags", {b64.o_sysins, b64.o_ecall, b64.o_rdwen}, 3'b110);
        step(1'b1, 32'h3020_0073, 64'h8000_0010, 1'b1);
        chk("mret", b64.o_mret, 1'b1);
        step(1'b1, 32'h0000_0000, 64'h8000_0014, 1'b1);
        chk("zero_ill_wen", {b64.o_illegal, b64.o_rdwen}, 2'b10);
        step(1'b1, 32'h0000_009B, 64'h8000_0018, 1'b1);
        chk("addiw_64", {b64.o_w32, b64.o_illegal}, 2'b10);
        chk("addiw_32", {b32.o_w32, b32.o_illegal}, 2'b01);
        step(1'b1, 32'h0010_0813, 64'h8000_001c, 1'b1);
        chk("x16_rve", {b32.o_illegal, b32.o_rdwen}, 2'b10);
        chk("x16_rv64", {b64.o_illegal, b64.o_rdwen}, 2'b01);
        step(1'b0, 32'h0, 64'h0, 1'b1);

        // stall downstream, push A,B,C; C must wait upstream
        step(1'b1, 32'h0010_0093, 64'h100, 1'b0);
        step(1'b1, 32'h0020_0113, 64'h104, 1'b0);
        chk("full_ready", b64.o_ready, 1'b0);
        step(1'b1, 32'h0030_0193, 64'h108, 1'b0);
        chk("held_A", b64.o_pc, 64'h100);
        step(1'b1, 32'h0030_0193, 64'h108, 1'b1);
        chk("out_B", b64.o_pc, 64'h104);
        step(1'b1, 32'h0030_0193, 64'h108, 1'b1);
        chk("out_C", b64.o_pc, 64'h108);
        step(1'b0, 32'h0, 64'h0, 1'b1);
        chk("drained", b64.o_valid, 1'b0);

        // streaming in state ONE
        step(1'b1, gen_ins(), 64'h200, 1'b0);
        dut_in = 0;
        dut_out = 0;
        for (int i = 0; i < 10; i++) step(1'b1, gen_ins(), 64'h204 + 64'(4 * i), 1'b1);
        chk("thru_in", 64'(dut_in), 64'd10);
        chk("thru_out", 64'(dut_out), 64'd10);
        step(1'b0, 32'h0, 64'h0, 1'b1);

        // async reset while two entries are held
        step(1'b1, 32'h0010_0093, 64'h300, 1'b0);
        step(1'b1, 32'h0020_0113, 64'h304, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid64", b64.o_valid, 1'b0);
        chk("async_rst_valid32", b32.o_valid, 1'b0);
        chk("async_rst_ready", b64.o_ready, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, gen_ins(), {$urandom, $urandom}, $urandom_range(0, 2) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
